hwpe_tcdm_responder: RTL and testbench

Memory-side responder for the HWPE TCDM initiator ports of the PULP cluster. It terminates N_PORTS HWPE master ports on a single-bank, word-addressed SRAM model and arbitrates between them round-robin. Reads return data with a fixed one-cycle latency. It is used as the TCDM end in out-of-context HWPE integration benches and cluster stubs, in place of the full cluster interconnect.

---
 rtl/hwpe_tcdm_responder_pkg.sv | 22 ++
 rtl/pulp_cluster_hwpe_pkg.sv | 6 +
 rtl/hwpe_tcdm_responder_if.sv | 26 ++
 rtl/hwpe_tcdm_responder_rr_arbiter.sv | 49 ++++
 rtl/hwpe_tcdm_responder.sv | 92 +++++++++
 tb/tb_hwpe_tcdm_responder.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/hwpe_tcdm_responder_pkg.sv
// rtl/hwpe_tcdm_responder_pkg.sv - TCDM widths, request/response structs, constants
package hwpe_tcdm_responder_pkg;

  localparam int unsigned TCDM_DW = 32;
  localparam int unsigned TCDM_AW = 32;
  localparam int unsigned TCDM_BW = 4;

  typedef struct packed {
    logic [TCDM_AW-1:0] add;
    logic               wen;
    logic [TCDM_BW-1:0] be;
    logic [TCDM_DW-1:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic [TCDM_DW-1:0] r_data;
    logic               r_valid;
  } tcdm_rsp_t;

  localparam logic [TCDM_DW-1:0] OOR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/pulp_cluster_hwpe_pkg.sv
// rtl/pulp_cluster_hwpe_pkg.sv - cluster-level HWPE configuration constants
package pulp_cluster_hwpe_pkg;

  localparam int unsigned N_HWPE_PORTS = 2;

endpackage

// File: rtl/hwpe_tcdm_responder_if.sv
// rtl/hwpe_tcdm_responder_if.sv - bundle of N HWPE TCDM initiator ports
interface hwpe_tcdm_responder_if #(
  parameter int unsigned N_PORTS = pulp_cluster_hwpe_pkg::N_HWPE_PORTS
) ();
  import hwpe_tcdm_responder_pkg::*;

  logic [N_PORTS-1:0]              tcdm_req_i;
  logic [N_PORTS-1:0]              tcdm_gnt_o;
  logic [N_PORTS-1:0][TCDM_AW-1:0] tcdm_add_i;
  logic [N_PORTS-1:0]              tcdm_wen_i;
  logic [N_PORTS-1:0][TCDM_BW-1:0] tcdm_be_i;
  logic [N_PORTS-1:0][TCDM_DW-1:0] tcdm_data_i;
  logic [N_PORTS-1:0][TCDM_DW-1:0] tcdm_r_data_o;
  logic [N_PORTS-1:0]              tcdm_r_valid_o;

  modport master (
    output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
    input  tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );

  modport slave (
    input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_be_i, tcdm_data_i,
    output tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );

endinterface

// File: rtl/hwpe_tcdm_responder_rr_arbiter.sv
// rtl/hwpe_tcdm_responder_rr_arbiter.sv - round-robin arbiter, one-hot grant plus index
module hwpe_rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index
);

  logic [IW-1:0] last_ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // Search starts one past the last winner and wraps; the extra sum bit absorbs the wrap.
  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum = {1'b0, last_ptr} + (IW+1)'(1) + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        index     = cand;
      end
    end
    if (rst) begin
      gnt   = '0;
      index = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ptr <= IW'(N - 1);
    end else if (|gnt) begin
      last_ptr <= index;
    end
  end

endmodule

// File: rtl/hwpe_tcdm_responder.sv
// rtl/hwpe_tcdm_responder.sv - single-bank TCDM SRAM model serving N HWPE ports
module hwpe_tcdm_responder #(
  parameter int unsigned N_PORTS = pulp_cluster_hwpe_pkg::N_HWPE_PORTS,
  parameter int unsigned DEPTH   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hwpe_tcdm_responder_if.slave  tcdm,
  output logic                  err_o,
  output logic [31:0]           gnt_cnt_o
);
  import hwpe_tcdm_responder_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]              gnt;
  logic [IW-1:0]                   gnt_idx;
  logic                            any_gnt;
  tcdm_req_t                       sel;
  logic                            oor;
  logic [AW-1:0]                   widx;
  logic [TCDM_DW-1:0]              rd_word;
  logic [TCDM_DW-1:0]              mem [DEPTH];
  tcdm_rsp_t [N_PORTS-1:0]         rsp_q;
  logic [N_PORTS-1:0][TCDM_DW-1:0] r_data;
  logic [N_PORTS-1:0]              r_valid;
  logic                            err_q;
  logic [31:0]                     gnt_cnt_q;

  hwpe_rr_arbiter #(.N(N_PORTS)) i_arb (
    .clk   (clk_i),
    .rst   (rst_i),
    .req   (tcdm.tcdm_req_i),
    .gnt   (gnt),
    .index (gnt_idx)
  );

  assign any_gnt = |gnt;

  always_comb begin
    sel.add  = tcdm.tcdm_add_i[gnt_idx];
    sel.wen  = tcdm.tcdm_wen_i[gnt_idx];
    sel.be   = tcdm.tcdm_be_i[gnt_idx];
    sel.data = tcdm.tcdm_data_i[gnt_idx];
  end

  // Any address bit above the word index makes the access out of range.
  assign oor     = |(sel.add >> (AW + 2));
  assign widx    = sel.add[AW+1:2];
  assign rd_word = oor ? OOR_RDATA : mem[widx];

  always_ff @(posedge clk_i) begin
    if (any_gnt && !sel.wen && !oor) begin
      for (int b = 0; b < int'(TCDM_BW); b++) begin
        if (sel.be[b]) mem[widx][8*b +: 8] <= sel.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_q     <= '0;
      err_q     <= 1'b0;
      gnt_cnt_q <= '0;
    end else begin
      for (int p = 0; p < int'(N_PORTS); p++) begin
        rsp_q[p].r_valid <= gnt[p];
        if (gnt[p] && sel.wen) rsp_q[p].r_data <= rd_word;
      end
      if (any_gnt && oor) err_q <= 1'b1;
      if (any_gnt) gnt_cnt_q <= gnt_cnt_q + 32'd1;
    end
  end

  // A response registered just before reset must not leak out while reset is held.
  always_comb begin
    r_data  = '0;
    r_valid = '0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      r_data[p]  = rsp_q[p].r_data;
      r_valid[p] = rsp_q[p].r_valid & ~rst_i;
    end
  end

  assign tcdm.tcdm_gnt_o     = gnt;
  assign tcdm.tcdm_r_data_o  = r_data;
  assign tcdm.tcdm_r_valid_o = r_valid;
  assign err_o               = err_q;
  assign gnt_cnt_o           = gnt_cnt_q;

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// tb/tb_hwpe_tcdm_responder.sv - self-checking bench with a transaction-level memory model
module tb_hwpe_tcdm_responder;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        err;
  logic [31:0] gnt_cnt;

  always #5 clk = ~clk;

  hwpe_tcdm_responder_if #(.N_PORTS(N)) bus ();

  hwpe_tcdm_responder #(.N_PORTS(N), .DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tcdm      (bus),
    .err_o     (err),
    .gnt_cnt_o (gnt_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // stimulus for the current cycle
  logic         s_rst;
  logic [N-1:0] s_req, s_wen;
  logic [31:0]  s_add [N];
  logic [31:0]  s_data [N];
  logic [3:0]   s_be [N];

  // reference model state
  logic [31:0]  m_mem [DEPTH];
  logic [3:0]   m_known [DEPTH];
  logic [N-1:0] m_pv, m_prd;
  logic [31:0]  m_rd [N];
  logic [31:0]  m_rm [N];
  logic         m_err;
  logic [31:0]  m_cnt;
  int           m_last;
  bit           m_sync = 1'b0;

  // observations from the latest cycle
  logic [N-1:0] last_g;
  logic [N-1:0] obs_rvalid;
  logic [31:0]  obs_rdata [N];

  task automatic set_req(input int p, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    s_req[p]  = 1'b1;
    s_wen[p]  = !wr;
    s_add[p]  = a;
    s_data[p] = d;
    s_be[p]   = be;
  endtask

  task automatic step();
    int           w;
    logic [N-1:0] eg;
    int unsigned  wi;
    bit           oor;
    logic [31:0]  mask;
    rst = s_rst;
    for (int p = 0; p < int'(N); p++) begin
      bus.tcdm_req_i[p]  = s_req[p];
      bus.tcdm_wen_i[p]  = s_wen[p];
      bus.tcdm_add_i[p]  = s_add[p];
      bus.tcdm_data_i[p] = s_data[p];
      bus.tcdm_be_i[p]   = s_be[p];
    end
    @(negedge clk);
    w  = -1;
    eg = '0;
    if (!s_rst) begin
      for (int i = 0; i < int'(N); i++) begin
        int c;
        c = (m_last + 1 + i) % int'(N);
        if (w < 0 && s_req[c]) w = c;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    last_g     = bus.tcdm_gnt_o;
    obs_rvalid = bus.tcdm_r_valid_o;
    for (int p = 0; p < int'(N); p++) obs_rdata[p] = bus.tcdm_r_data_o[p];
    check("gnt", 32'(last_g), 32'(eg));
    if (s_rst) check("r_valid_in_rst", 32'(obs_rvalid), 32'd0);
    else if (m_sync) begin
      check("r_valid", 32'(obs_rvalid), 32'(m_pv));
      for (int p = 0; p < int'(N); p++)
        if (m_pv[p] && m_prd[p] && m_rm[p] != 0)
          check("r_data", obs_rdata[p] & m_rm[p], m_rd[p] & m_rm[p]);
    end
    if (m_sync) begin
      check("err", 32'(err), 32'(m_err));
      check("gnt_cnt", gnt_cnt, m_cnt);
    end
    if (s_rst) begin
      m_pv   = '0;
      m_err  = 1'b0;
      m_cnt  = '0;
      m_last = int'(N) - 1;
      m_sync = 1'b1;
    end else begin
      m_pv  = eg;
      m_prd = '0;
      if (w >= 0) begin
        m_cnt  = m_cnt + 32'd1;
        m_last = w;
        oor    = (s_add[w] >> 12) != 0;
        wi     = int'(s_add[w][11:2]);
        if (oor) m_err = 1'b1;
        if (s_wen[w]) begin
          m_prd[w] = 1'b1;
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = m_known[wi][b] ? 8'hFF : 8'h00;
          m_rd[w] = oor ? 32'h0 : m_mem[wi];
          m_rm[w] = oor ? 32'hFFFF_FFFF : mask;
        end else if (!oor) begin
          for (int b = 0; b < 4; b++) if (s_be[w][b]) begin
            m_mem[wi][8*b +: 8] = s_data[w][8*b +: 8];
            m_known[wi][b]      = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_known[i] = 4'h0;
      m_mem[i]   = 32'h0;
    end
    m_pv = '0; m_prd = '0; m_err = 1'b0; m_cnt = '0; m_last = int'(N) - 1;
    for (int p = 0; p < int'(N); p++) begin
      s_add[p] = '0; s_data[p] = '0; s_be[p] = '0; m_rd[p] = '0; m_rm[p] = '0;
    end
    s_req = '0; s_wen = '1; s_rst = 1'b1;
    step(); step();
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", gnt_cnt, 32'd0);
    s_rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
      step();
      check("rr_seq", 32'(last_g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    s_req = '0;
    step();
    check("rr_tail_rvalid", 32'(obs_rvalid), 32'd2);

    s_rst = 1'b1; step(); s_rst = 1'b0;
    set_req(0, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF); step();
    s_req = '0; set_req(0, 1'b0, 32'h10, 32'h0, 4'h0); step();
    s_req = '0; step();
    check("t1_rvalid", 32'(obs_rvalid), 32'd1);
    check("t1_rdata", obs_rdata[0], 32'hCAFE_F00D);
    check("t1_cnt", gnt_cnt, 32'd2);

    set_req(1, 1'b1, 32'h20, 32'h1122_3344, 4'hF); step();
    s_req = '0; set_req(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101); step();
    s_req = '0; set_req(1, 1'b0, 32'h21, 32'h0, 4'h0); step();
    s_req = '0; step();
    check("be_merge", obs_rdata[1], 32'h11BB_33DD);

    set_req(1, 1'b1, 32'h0, 32'h0123_4567, 4'hF); step();
    s_req = '0; check("pre_oor_err", 32'(err), 32'd0);
    set_req(1, 1'b1, 32'h1000, 32'h5A5A_5A5A, 4'hF); step();
    s_req = '0; check("oor_err_set", 32'(err), 32'd1);
    set_req(1, 1'b0, 32'h1000, 32'h0, 4'h0); step();
    s_req = '0; step();
    check("oor_rdata", obs_rdata[1], 32'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0); step();
    s_req = '0; step();
    check("oor_no_alias", obs_rdata[1], 32'h0123_4567);
    check("oor_err_sticky", 32'(err), 32'd1);

    for (int k = 0; k < 400; k++) begin
      s_req = '0;
      for (int p = 0; p < int'(N); p++) begin
        if ($urandom_range(3) != 0) begin
          logic [31:0] a;
          if ($urandom_range(15) == 0) a = (32'h1000 << $urandom_range(19)) | 32'($urandom_range(4095));
          else a = {20'h0, 10'(16 + $urandom_range(31)), 2'($urandom_range(3))};
          set_req(p, 1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)));
        end
      end
      step();
    end

    s_req = '0; set_req(0, 1'b0, 32'h10, 32'h0, 4'h0); step();
    s_req = '0; s_rst = 1'b1; step();
    check("rm_rvalid", 32'(obs_rvalid), 32'd0);
    s_rst = 1'b0;
    check("rm_cnt", gnt_cnt, 32'd0);
    check("rm_err", 32'(err), 32'd0);
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    step();
    check("rm_prio", 32'(last_g), 32'd1);
    s_req = '0; step();
    check("rm_retained", obs_rdata[0], 32'hCAFE_F00D);

    force dut.gnt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.gnt_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    s_req = '0; set_req(1, 1'b0, 32'h20, 32'h0, 4'h0); step();
    check("cnt_wrap", gnt_cnt, 32'h0);
    s_req = '0; step();
    check("wrap_rdata", obs_rdata[1], 32'h11BB_33DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
